// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell plus carry flop, sequenced LSB first,
// shared by two requesters under round-robin arbitration.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_owner;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;

  logic             w_any;
  logic             w_sel;
  logic             w_gnt;
  logic             w_last_bit;
  logic             w_s;
  logic             w_c_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    w_any = req0 | req1;
    w_sel = 1'b0;
    if (req0 && req1) w_sel = ~r_last;
    else              w_sel = req1;
  end

  assign w_gnt      = (r_state == S_IDLE) && w_any;
  assign gnt0       = w_gnt & ~w_sel;
  assign gnt1       = w_gnt & w_sel;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign w_last_bit = (r_cnt == LAST_BIT);

  assign w_s       = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c_nxt   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt) w_next = S_RUN;
      S_RUN:   if (w_last_bit) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_last = 1 after reset so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      sum     <= '0;
      cout    <= 1'b0;
      done_id <= 1'b0;
    end else begin
      if (w_gnt) r_last <= w_sel;
      if (r_state == S_RUN && w_last_bit) begin
        sum     <= w_res_nxt;
        cout    <= w_c_nxt;
        done_id <= r_owner;
      end
    end
  end

  // Working registers are always (re)loaded on a grant, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_gnt) begin
      r_a     <= w_sel ? a1 : a0;
      r_b     <= w_sel ? b1 : b0;
      r_c     <= w_sel ? cin1 : cin0;
      r_cnt   <= '0;
      r_owner <= w_sel;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_c_nxt;
      r_res <= w_res_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): reset, sums, carries,
// arbitration, busy lockout and reset during RUN.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, cin0, cin1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, done, done_id, cout;
  logic [7:0] sum;

  int checks = 0;
  int failures = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req0 = 0; req1 = 0; cin0 = 0; cin1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  // Runs one addition from the current IDLE cycle and reports what it saw.
  task automatic do_add(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic c, output logic g_ok, output logic busy_ok,
                        output int lat, output logic [7:0] s, output logic co,
                        output logic did);
    if (id) begin req1 = 1; a1 = a; b1 = b; cin1 = c; end
    else    begin req0 = 1; a0 = a; b0 = b; cin0 = c; end
    #1;
    g_ok    = id ? (gnt1 && !gnt0) : (gnt0 && !gnt1);
    busy_ok = !busy;
    step();
    req0 = 0; req1 = 0;
    lat = 1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 0;
      step();
      lat++;
    end
    if (!busy) busy_ok = 0;
    s = sum; co = cout; did = done_id;
    step();
  endtask

  task automatic test_reset();
    req0 = 0; req1 = 0; cin0 = 0; cin1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    rst_n = 0;
    step();
    checks++;
    if ({gnt0, gnt1, busy, done, done_id, cout, sum} !== 14'd0) begin
      failures++;
      $display("FAIL reset_held outputs=%b required=0", {gnt0, gnt1, busy, done, done_id, cout, sum});
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({gnt0, gnt1, busy, done, done_id, cout, sum} !== 14'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d outputs=%b required=0", i, {gnt0, gnt1, busy, done, done_id, cout, sum});
      end
    end
  endtask

  task automatic test_single_add();
    logic g_ok, b_ok, co, did;
    logic [7:0] s;
    int lat;
    do_add(1'b0, 8'h3C, 8'h5A, 1'b0, g_ok, b_ok, lat, s, co, did);
    checks++; if (g_ok !== 1'b1) begin failures++; $display("FAIL single_gnt got=%b required=1", g_ok); end
    checks++; if (b_ok !== 1'b1) begin failures++; $display("FAIL single_busy got=%b required=1", b_ok); end
    checks++; if (lat != 9) begin failures++; $display("FAIL single_latency got=%0d required=9", lat); end
    checks++; if (s !== 8'h96) begin failures++; $display("FAIL single_sum got=%h required=96", s); end
    checks++; if (co !== 1'b0) begin failures++; $display("FAIL single_cout got=%b required=0", co); end
    checks++; if (did !== 1'b0) begin failures++; $display("FAIL single_id got=%b required=0", did); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL single_after busy=%b done=%b required=0,0", busy, done);
    end
    step();
    checks++; if (sum !== 8'h96) begin failures++; $display("FAIL single_hold sum=%h required=96", sum); end
  endtask

  task automatic test_carry_edges();
    logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] es [3] = '{8'h00, 8'hFF, 8'h01};
    logic       ec [3] = '{1'b1, 1'b1, 1'b0};
    logic g_ok, b_ok, co, did;
    logic [7:0] s;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_add(1'b0, va[i], vb[i], vc[i], g_ok, b_ok, lat, s, co, did);
      checks++;
      if (s !== es[i] || co !== ec[i]) begin
        failures++;
        $display("FAIL carry_edge%0d got=%h/%b required=%h/%b", i, s, co, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    apply_reset();
    a0 = 8'h01; b0 = 8'h02; cin0 = 0;
    a1 = 8'h10; b1 = 8'h11; cin1 = 0;
    req0 = 1; req1 = 1;
    for (int c = 0; c <= 31; c++) begin
      #1;
      checks++;
      if (gnt0 !== (c == 0 || c == 20) || gnt1 !== (c == 10 || c == 30)) begin
        failures++;
        $display("FAIL arb_grant cyc=%0d gnt0=%b gnt1=%b required=%b,%b",
                 c, gnt0, gnt1, (c == 0 || c == 20), (c == 10 || c == 30));
      end
      if (c == 9 || c == 19) begin
        checks++;
        if (done !== 1'b1 || done_id !== (c == 19) || sum !== ((c == 19) ? 8'h21 : 8'h03)) begin
          failures++;
          $display("FAIL arb_done cyc=%0d done=%b id=%b sum=%h", c, done, done_id, sum);
        end
      end
      @(posedge clk);
      #1;
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_busy_lockout();
    apply_reset();
    a0 = 8'h7F; b0 = 8'h01; cin0 = 0;
    a1 = 8'h22; b1 = 8'h33; cin1 = 0;
    req0 = 1;
    for (int c = 0; c <= 20; c++) begin
      if (c == 1) req0 = 0;
      if (c == 3) req1 = 1;
      if (c == 11) req1 = 0;
      #1;
      if (c >= 1 && c <= 10) begin
        checks++;
        if (gnt1 !== (c == 10)) begin
          failures++;
          $display("FAIL lock_gnt1 cyc=%0d got=%b required=%b", c, gnt1, (c == 10));
        end
      end
      if (c == 9) begin
        checks++;
        if (done !== 1'b1 || done_id !== 1'b0 || sum !== 8'h80 || cout !== 1'b0) begin
          failures++;
          $display("FAIL lock_r0 done=%b id=%b sum=%h cout=%b required=1,0,80,0", done, done_id, sum, cout);
        end
      end
      if (c == 19) begin
        checks++;
        if (done !== 1'b1 || done_id !== 1'b1 || sum !== 8'h55) begin
          failures++;
          $display("FAIL lock_r1 done=%b id=%b sum=%h required=1,1,55", done, done_id, sum);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_run();
    logic g_ok, b_ok, co, did;
    logic [7:0] s;
    int lat;
    int seen_done;
    apply_reset();
    do_add(1'b0, 8'h3C, 8'h5A, 1'b0, g_ok, b_ok, lat, s, co, did);
    req0 = 1; a0 = 8'hAA; b0 = 8'h55; cin0 = 0;
    step();
    req0 = 0;
    step(); step(); step();
    rst_n = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || sum !== 8'h00 || done !== 1'b0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs busy=%b sum=%h done=%b cout=%b required=0,00,0,0", busy, sum, done, cout);
    end
    #1;
    rst_n = 1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++; $display("FAIL midrst_nodone pulses=%0d required=0", seen_done);
    end
    do_add(1'b1, 8'h10, 8'h20, 1'b0, g_ok, b_ok, lat, s, co, did);
    checks++;
    if (g_ok !== 1'b1 || s !== 8'h30 || co !== 1'b0 || did !== 1'b1 || lat != 9) begin
      failures++;
      $display("FAIL midrst_readd gnt=%b sum=%h cout=%b id=%b lat=%0d required=1,30,0,1,9", g_ok, s, co, did, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_carry_edges();
    test_arbitration();
    test_busy_lockout();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
